// File: rtl/load_store_unit.sv
// Data-memory access stage: byte/half/word loads with sign/zero extension and
// sub-word stores done as read-modify-write against a whole-word write strobe.
module load_store_unit #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_data_out [0:3],
   output logic [7:0]  mem_data_in  [0:3],
   output logic        mem_write_en
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

   localparam logic [1:0] LAST = 2'(MEM_LATENCY - 1);

   state_t            state, state_nxt;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [31:0]       addr_q, wdata_q, rdata_q;
   logic              err_q;
   logic [1:0]        cnt_q;
   logic [3:0][7:0]   buf_q, rd_word, wr_lane;
   logic              accept, acc_err, acc_mis, acc_legal, rd_last;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_data;

   assign accept  = req_valid && (state == IDLE);
   assign rd_last = (state == RD_WAIT) && (cnt_q == LAST);

   always_comb begin
      acc_legal = 1'b0;
      if (req_we) acc_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else        acc_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
      acc_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      acc_err = !acc_legal || acc_mis;
   end

   always_comb begin
      for (int i = 0; i < 4; i++) rd_word[i] = mem_data_out[i];
   end

   // Sign is selected by funct3[2]: 0 = sign-extend (LB/LH), 1 = zero-extend.
   always_comb begin
      ld_byte = rd_word[addr_q[1:0]];
      ld_half = {rd_word[{addr_q[1], 1'b1}], rd_word[{addr_q[1], 1'b0}]};
      case (f3_q[1:0])
         2'b00:   ld_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
         2'b01:   ld_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
         default: ld_data = rd_word;
      endcase
   end

   always_comb begin
      wr_lane = buf_q;
      for (int i = 0; i < 4; i++) begin
         case (f3_q[1:0])
            2'b00:   if (2'(i) == addr_q[1:0]) wr_lane[i] = wdata_q[7:0];
            2'b01:   if (i[1] == addr_q[1]) wr_lane[i] = i[0] ? wdata_q[15:8] : wdata_q[7:0];
            default: wr_lane[i] = wdata_q[8*i +: 8];
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (acc_err)                                state_nxt = RESP;
               else if (req_we && req_funct3 == 3'b010)    state_nxt = WRITE;
               else                                        state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: if (rd_last) state_nxt = we_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= acc_err;
            rdata_q <= '0;
            cnt_q   <= '0;
         end else if (state == RD_WAIT) begin
            cnt_q <= cnt_q + 2'd1;
            if (rd_last) begin
               buf_q <= rd_word;
               if (!we_q) rdata_q <= ld_data;
            end
         end
      end
   end

   assign req_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign resp_valid   = (state == RESP);
   assign resp_rdata   = (state == RESP) ? rdata_q : 32'h0;
   assign resp_err     = (state == RESP) && err_q;
   assign mem_write_en = (state == WRITE);
   assign mem_addr     = (state == RD_WAIT || state == WRITE) ? {addr_q[31:2], 2'b00} : 32'h0;

   always_comb begin
      for (int i = 0; i < 4; i++) mem_data_in[i] = (state == WRITE) ? wr_lane[i] : 8'h00;
   end

endmodule
